// File: rtl/round_tracker_if.sv
// round_tracker_if
//   Groups the round controller's stimulus and status signals.
//   master : the game-side driver (start/board/guess in, status out)
//   slave  : the round_tracker itself
//   Inputs to the tracker : start, board, guess_valid, guess
//   Outputs of the tracker: display, found, remaining, showing, won, lost, score
interface round_tracker_if #(
    parameter int BOARD_W = 8
);
    logic               start;
    logic [BOARD_W-1:0] board;
    logic               guess_valid;
    logic [BOARD_W-1:0] guess;
    logic [BOARD_W-1:0] display;
    logic [BOARD_W-1:0] found;
    logic [3:0]         remaining;
    logic               showing;
    logic               won;
    logic               lost;
    logic [7:0]         score;

    modport master (
        output start, board, guess_valid, guess,
        input  display, found, remaining, showing, won, lost, score
    );

    modport slave (
        input  start, board, guess_valid, guess,
        output display, found, remaining, showing, won, lost, score
    );
endinterface

// File: rtl/round_tracker.sv
// round_tracker
//   Round controller for the Memory Matrix game. Latches the target board on
//   start, shows it for SHOW_CYCLES clocks, then consumes one checked guess
//   per guess_valid pulse until every target tile is found (WIN) or the
//   guesses run out (LOSE). Keeps a saturating count of rounds won.
// Ports
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   bus    : round_tracker_if.slave
//            in  start, board, guess_valid, guess
//            out display, found, remaining, showing, won, lost, score
//   All outputs come straight from registers.
module round_tracker #(
    parameter int BOARD_W     = 8,
    parameter int GUESSES     = 7,
    parameter int SHOW_CYCLES = 100_000_000
) (
    input logic            clk,
    input logic            reset,
    round_tracker_if.slave bus
);
    localparam int TIMER_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] SHOW_LAST = TIMER_W'(SHOW_CYCLES - 1);
    localparam logic [3:0]         GUESS_INIT = 4'(GUESSES);

    typedef enum logic [2:0] {IDLE, SHOW, GUESS, WIN, LOSE} state_t;

    state_t             state;
    logic [BOARD_W-1:0] target;
    logic [TIMER_W-1:0] timer;
    logic [BOARD_W-1:0] display;
    logic [BOARD_W-1:0] found;
    logic [3:0]         remaining;
    logic               showing;
    logic               won;
    logic               lost;
    logic [7:0]         score;

    // Tiles of the target this guess covers, and the subset not yet found.
    logic [BOARD_W-1:0] covered;
    logic [BOARD_W-1:0] hit;
    logic [BOARD_W-1:0] found_next;

    assign covered    = bus.guess & target;
    assign hit        = covered & ~found;
    assign found_next = found | hit;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            target    <= '0;
            timer     <= '0;
            display   <= '0;
            found     <= '0;
            remaining <= '0;
            showing   <= 1'b0;
            won       <= 1'b0;
            lost      <= 1'b0;
            score     <= '0;
        end else begin
            case (state)
                IDLE, WIN, LOSE: begin
                    // Guesses arriving here are simply dropped.
                    if (bus.start) begin
                        state     <= SHOW;
                        target    <= bus.board;
                        timer     <= '0;
                        found     <= '0;
                        remaining <= GUESS_INIT;
                        display   <= bus.board;
                        showing   <= 1'b1;
                        won       <= 1'b0;
                        lost      <= 1'b0;
                    end
                end
                SHOW: begin
                    if (timer == SHOW_LAST) begin
                        showing <= 1'b0;
                        if (target == '0) begin
                            // Nothing to find: the round is won outright.
                            state   <= WIN;
                            won     <= 1'b1;
                            score   <= sat_inc(score);
                            display <= target;
                        end else begin
                            state   <= GUESS;
                            display <= found;
                        end
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                GUESS: begin
                    if (bus.guess_valid) begin
                        if (hit != '0) begin
                            found <= found_next;
                            if (found_next == target) begin
                                state   <= WIN;
                                won     <= 1'b1;
                                score   <= sat_inc(score);
                                display <= target;
                            end else begin
                                display <= found_next;
                            end
                        end else if (covered == '0) begin
                            // Miss (including an empty guess). remaining is
                            // at least 1 here, so it cannot underflow.
                            remaining <= remaining - 4'd1;
                            if (remaining == 4'd1) begin
                                state   <= LOSE;
                                lost    <= 1'b1;
                                display <= target;
                            end
                        end
                        // Otherwise only already-found tiles were guessed:
                        // nothing changes.
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.display   = display;
    assign bus.found     = found;
    assign bus.remaining = remaining;
    assign bus.showing   = showing;
    assign bus.won       = won;
    assign bus.lost      = lost;
    assign bus.score     = score;
endmodule

// File: tb/tb_round_tracker.sv
// tb_round_tracker
//   Self-checking bench for round_tracker (BOARD_W=8, GUESSES=3,
//   SHOW_CYCLES=4). Expected output snapshots are queued as stimulus is
//   driven and compared once the DUT has taken the clock edge.
module tb_round_tracker;
    logic clk;
    logic reset;

    round_tracker_if #(.BOARD_W(8)) bus ();

    round_tracker #(
        .BOARD_W    (8),
        .GUESSES    (3),
        .SHOW_CYCLES(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] display;
        logic [7:0] found;
        logic [3:0] remaining;
        logic       showing;
        logic       won;
        logic       lost;
        logic [7:0] score;
    } snap_t;

    snap_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic snap_t mk(input logic [7:0] d, input logic [7:0] f,
                                 input logic [3:0] r, input logic s,
                                 input logic w, input logic l,
                                 input logic [7:0] sc);
        snap_t v;
        v = {d, f, r, s, w, l, sc};
        return v;
    endfunction

    function automatic snap_t snap();
        snap_t v;
        v = {bus.display, bus.found, bus.remaining, bus.showing,
             bus.won, bus.lost, bus.score};
        return v;
    endfunction

    // Advance past the next active edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [7:0] b);
        bus.start = 1'b1;
        bus.board = b;
        tick();
        bus.start = 1'b0;
        bus.board = 8'h00;
    endtask

    task automatic drive_guess(input logic [7:0] g);
        bus.guess_valid = 1'b1;
        bus.guess       = g;
        tick();
        bus.guess_valid = 1'b0;
        bus.guess       = 8'h00;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        snap_t got, e;
        for (int i = 0; i < 6; i++) begin
            bus.start       = 1'($urandom_range(0, 1));
            bus.board       = 8'($urandom);
            bus.guess_valid = 1'($urandom_range(0, 1));
            bus.guess       = 8'($urandom);
            tick();
        end
        // reset together with start: start must be ignored
        exp_q.push_back(mk(8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0));
        reset = 1'b1;
        bus.start = 1'b1;
        bus.board = 8'hA5;
        bus.guess_valid = 1'b0;
        bus.guess = 8'h00;
        tick();
        reset = 1'b0;
        bus.start = 1'b0;
        bus.board = 8'h00;
        e = exp_q.pop_front(); got = snap(); checks++;
        if (got !== e) begin errors++; $display("FAIL reset_state: got %h expected %h", got, e); end
        exp_q.push_back(mk(8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0));
        tick();
        e = exp_q.pop_front(); got = snap(); checks++;
        if (got !== e) begin errors++; $display("FAIL reset_idle_hold: got %h expected %h", got, e); end
    endtask

    task automatic test_perfect();
        snap_t got, e;
        logic [7:0] g[3]   = '{8'h01, 8'h04, 8'h20};
        logic [7:0] f[3]   = '{8'h01, 8'h05, 8'h25};
        logic [7:0] d[3]   = '{8'h01, 8'h05, 8'h25};
        logic       w[3]   = '{1'b0, 1'b0, 1'b1};
        logic [7:0] sc[3]  = '{8'd0, 8'd0, 8'd1};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk(8'h25, 8'h00, 4'd3, 1'b1, 1'b0, 1'b0, 8'd0));
            if (i == 0) drive_start(8'h25); else tick();
            e = exp_q.pop_front(); got = snap(); checks++;
            if (got !== e) begin errors++; $display("FAIL perfect_show%0d: got %h expected %h", i, got, e); end
        end
        exp_q.push_back(mk(8'h00, 8'h00, 4'd3, 1'b0, 1'b0, 1'b0, 8'd0));
        tick();
        e = exp_q.pop_front(); got = snap(); checks++;
        if (got !== e) begin errors++; $display("FAIL perfect_enter_guess: got %h expected %h", got, e); end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(d[i], f[i], 4'd3, 1'b0, w[i], 1'b0, sc[i]));
            drive_guess(g[i]);
            e = exp_q.pop_front(); got = snap(); checks++;
            if (got !== e) begin errors++; $display("FAIL perfect_guess%0d: got %h expected %h", i, got, e); end
        end
    endtask

    task automatic test_loss();
        snap_t got, e;
        logic [7:0] g[3] = '{8'h02, 8'h04, 8'h08};
        logic [7:0] d[3] = '{8'h00, 8'h00, 8'h81};
        logic [3:0] r[3] = '{4'd2, 4'd1, 4'd0};
        logic       l[3] = '{1'b0, 1'b0, 1'b1};
        drive_start(8'h81);
        exp_q.push_back(mk(8'h00, 8'h00, 4'd3, 1'b0, 1'b0, 1'b0, 8'd1));
        idle_ticks(4);
        e = exp_q.pop_front(); got = snap(); checks++;
        if (got !== e) begin errors++; $display("FAIL loss_enter_guess: got %h expected %h", got, e); end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(d[i], 8'h00, r[i], 1'b0, 1'b0, l[i], 8'd1));
            drive_guess(g[i]);
            e = exp_q.pop_front(); got = snap(); checks++;
            if (got !== e) begin errors++; $display("FAIL loss_guess%0d: got %h expected %h", i, got, e); end
        end
    endtask

    task automatic test_repeat_zero();
        snap_t got, e;
        logic [7:0] g[4]  = '{8'h01, 8'h01, 8'h00, 8'h03};
        logic [7:0] f[4]  = '{8'h01, 8'h01, 8'h01, 8'h03};
        logic [3:0] r[4]  = '{4'd3, 4'd3, 4'd2, 4'd2};
        logic       w[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] sc[4] = '{8'd1, 8'd1, 8'd1, 8'd2};
        drive_start(8'h03);
        idle_ticks(4);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk(f[i], f[i], r[i], 1'b0, w[i], 1'b0, sc[i]));
            drive_guess(g[i]);
            e = exp_q.pop_front(); got = snap(); checks++;
            if (got !== e) begin errors++; $display("FAIL repeat_guess%0d: got %h expected %h", i, got, e); end
        end
    endtask

    task automatic test_ignored();
        snap_t got, e;
        drive_start(8'h0C);
        // guess held through the whole window, including the SHOW->GUESS edge
        bus.guess_valid = 1'b1;
        bus.guess       = 8'h0C;
        exp_q.push_back(mk(8'h00, 8'h00, 4'd3, 1'b0, 1'b0, 1'b0, 8'd2));
        idle_ticks(4);
        bus.guess_valid = 1'b0;
        bus.guess       = 8'h00;
        e = exp_q.pop_front(); got = snap(); checks++;
        if (got !== e) begin errors++; $display("FAIL ignore_guess_in_show: got %h expected %h", got, e); end
        exp_q.push_back(mk(8'h00, 8'h00, 4'd3, 1'b0, 1'b0, 1'b0, 8'd2));
        drive_start(8'hFF);
        e = exp_q.pop_front(); got = snap(); checks++;
        if (got !== e) begin errors++; $display("FAIL ignore_start_in_guess: got %h expected %h", got, e); end
        // 0x10 would be a hit had the FF board been latched
        exp_q.push_back(mk(8'h00, 8'h00, 4'd2, 1'b0, 1'b0, 1'b0, 8'd2));
        drive_guess(8'h10);
        e = exp_q.pop_front(); got = snap(); checks++;
        if (got !== e) begin errors++; $display("FAIL ignore_target_kept: got %h expected %h", got, e); end
        exp_q.push_back(mk(8'h04, 8'h04, 4'd2, 1'b0, 1'b0, 1'b0, 8'd2));
        drive_guess(8'h04);
        e = exp_q.pop_front(); got = snap(); checks++;
        if (got !== e) begin errors++; $display("FAIL ignore_hit1: got %h expected %h", got, e); end
        exp_q.push_back(mk(8'h0C, 8'h0C, 4'd2, 1'b0, 1'b1, 1'b0, 8'd3));
        drive_guess(8'h08);
        e = exp_q.pop_front(); got = snap(); checks++;
        if (got !== e) begin errors++; $display("FAIL ignore_win: got %h expected %h", got, e); end
        exp_q.push_back(mk(8'h0C, 8'h0C, 4'd2, 1'b0, 1'b1, 1'b0, 8'd3));
        drive_guess(8'h01);
        e = exp_q.pop_front(); got = snap(); checks++;
        if (got !== e) begin errors++; $display("FAIL ignore_guess_in_win: got %h expected %h", got, e); end
        exp_q.push_back(mk(8'h30, 8'h00, 4'd3, 1'b1, 1'b0, 1'b0, 8'd3));
        drive_start(8'h30);
        e = exp_q.pop_front(); got = snap(); checks++;
        if (got !== e) begin errors++; $display("FAIL restart_from_win: got %h expected %h", got, e); end
    endtask

    task automatic test_back_to_back();
        snap_t got, e;
        // round for board 0x30 was started by the previous test
        exp_q.push_back(mk(8'h00, 8'h00, 4'd3, 1'b0, 1'b0, 1'b0, 8'd3));
        idle_ticks(4);
        e = exp_q.pop_front(); got = snap(); checks++;
        if (got !== e) begin errors++; $display("FAIL b2b_enter_guess: got %h expected %h", got, e); end
        exp_q.push_back(mk(8'h10, 8'h10, 4'd3, 1'b0, 1'b0, 1'b0, 8'd3));
        exp_q.push_back(mk(8'h30, 8'h30, 4'd3, 1'b0, 1'b1, 1'b0, 8'd4));
        bus.guess_valid = 1'b1;
        bus.guess       = 8'h10;
        tick();
        e = exp_q.pop_front(); got = snap(); checks++;
        if (got !== e) begin errors++; $display("FAIL b2b_first: got %h expected %h", got, e); end
        bus.guess = 8'h20;
        tick();
        bus.guess_valid = 1'b0;
        bus.guess       = 8'h00;
        e = exp_q.pop_front(); got = snap(); checks++;
        if (got !== e) begin errors++; $display("FAIL b2b_second: got %h expected %h", got, e); end
    endtask

    task automatic test_reset_mid();
        snap_t got, e;
        drive_start(8'h01);
        idle_ticks(4);
        exp_q.push_back(mk(8'h00, 8'h00, 4'd2, 1'b0, 1'b0, 1'b0, 8'd4));
        drive_guess(8'h02);
        e = exp_q.pop_front(); got = snap(); checks++;
        if (got !== e) begin errors++; $display("FAIL mid_miss: got %h expected %h", got, e); end
        exp_q.push_back(mk(8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0));
        reset           = 1'b1;
        bus.guess_valid = 1'b1;
        bus.guess       = 8'h01;
        tick();
        reset           = 1'b0;
        bus.guess_valid = 1'b0;
        bus.guess       = 8'h00;
        e = exp_q.pop_front(); got = snap(); checks++;
        if (got !== e) begin errors++; $display("FAIL mid_reset: got %h expected %h", got, e); end
    endtask

    task automatic test_saturation();
        snap_t got, e;
        for (int r = 0; r < 256; r++) begin
            exp_q.push_back(mk(8'h00, 8'h00, 4'd3, 1'b0, 1'b1, 1'b0,
                               (r < 255) ? 8'(r + 1) : 8'd255));
            drive_start(8'h00);
            idle_ticks(4);
            e = exp_q.pop_front(); got = snap(); checks++;
            if (got !== e) begin errors++; $display("FAIL sat_round%0d: got %h expected %h", r, got, e); end
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.board       = 8'h00;
        bus.guess_valid = 1'b0;
        bus.guess       = 8'h00;
        idle_ticks(2);
        reset = 1'b0;
        test_reset();
        test_perfect();
        test_loss();
        test_repeat_zero();
        test_ignored();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/round_tracker.md
# round_tracker

Round controller for the Memory Matrix game, sitting directly downstream of the guess checker. It latches the target board, shows it for a fixed memorize window, and then consumes one checked guess per `guess_valid` pulse. It maintains the found-tile and remaining-guess registers and declares win or loss. It also keeps a saturating count of rounds won, which feeds the HEX and LEDR display logic.

## Interface
- `BOARD_W`, default 8: board/guess width, one bit per tile.
- `GUESSES`, default 7: guesses per round, legal range 1..15.
- `SHOW_CYCLES`, default 100_000_000: memorize window length in clocks (2 s at 50 MHz), must be ≥1.

Clock and reset: one clock; reset is synchronous and active-high.

- `clk`  in  1  system clock (CLOCK_50).
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a round.
- `board`  in  BOARD_W  target pattern, sampled only on an accepted `start`.
- `guess_valid`  in  1  one-cycle pulse; `guess` is valid this cycle.
- `guess`  in  BOARD_W  tile(s) guessed.
- `display`  out  BOARD_W  tiles to light.
- `found`  out  BOARD_W  tiles correctly found this round.
- `remaining`  out  4  guesses left.
- `showing`  out  1  high in SHOW.
- `won`  out  1  high in WIN.
- `lost`  out  1  high in LOSE.
- `score`  out  8  rounds won since reset, saturates at 255.

## Operation
- States: IDLE, SHOW, GUESS, WIN, LOSE. All outputs are registered or decoded from registered state; there are no combinational input-to-output paths.
- Internal registers: `target` (BOARD_W), `timer` (wide enough to hold SHOW_CYCLES-1).
- `start` is accepted only in IDLE, WIN or LOSE. On acceptance:
  - `target` ← `board`, `found` ← 0, `remaining` ← GUESSES, `timer` ← 0.
  - Next state is SHOW.
- `start` is ignored in SHOW and GUESS.
- SHOW:
  - `display` = `target`.
  - `timer` increments each cycle. When `timer` == SHOW_CYCLES-1, the next state is GUESS.
  - If `target` == 0 at that point, the next state is WIN instead.
  - `guess_valid` is ignored.
- GUESS:
  - `display` = `found`.
  - On `guess_valid`, let `new` = `guess` & `target` & ~`found`:
    - `new` ≠ 0 (hit): `found` ← `found` | `new`. `remaining` is unchanged. If (`found` | `new`) == `target`, next state is WIN.
    - `new` == 0 and (`guess` & `target`) ≠ 0 (repeat of an already-found tile): no change to any register.
    - (`guess` & `target`) == 0, including `guess` == 0 (miss): `remaining` ← `remaining`-1. If the new value is 0, next state is LOSE.
  - A multi-bit `guess` credits every new target bit it covers.
- WIN:
  - `display` = `target`, `won` = 1.
  - `score` increments once, on the transition into WIN, saturating at 255.
- LOSE: `display` = `target`, `lost` = 1.
- IDLE: `display` = 0.
- `score` clears only on `reset`. It persists across rounds.

## Timing
- Reset values:
  - State is IDLE.
  - `display`, `found`, `target`, `timer` are 0.
  - `remaining` = 0, `score` = 0.
  - `showing`, `won`, `lost` are 0.
- `reset` overrides every other input, including mid-round and in the same cycle as `start` or `guess_valid`.
- Start latency: with `start` sampled at edge E0, `showing` = 1 and `display` = `target` for exactly SHOW_CYCLES cycles after E0. At edge E0+SHOW_CYCLES the state becomes GUESS (or WIN if the board is empty).
- `guess_valid` is acted on only if the state is already GUESS at the sampling edge. A pulse coincident with the SHOW→GUESS edge is dropped.
- Guess latency: `found`, `remaining`, `won`/`lost` and `score` reflect a guess one edge after the `guess_valid` pulse.
- Back-to-back `guess_valid` pulses on consecutive cycles are each processed.
- Once in WIN or LOSE, further guesses are ignored.
- `remaining` never underflows: the LOSE transition happens at 0 and no decrement occurs outside GUESS.

## Test plan
- **Reset:** drive random inputs, then `reset`=1 for 1 cycle → all outputs 0 and state IDLE. A `start` in the same cycle as `reset` is ignored.
- **Perfect round:** set SHOW_CYCLES=4, GUESSES=3, `board`=0x25, pulse `start`.
  - Required: `display`=0x25 and `showing`=1 for 4 cycles, then `display`=0x00.
  - Then guesses 0x01, 0x04, 0x20 → `found` = 0x01, then 0x05, then 0x25.
  - After the third guess: `won`=1, `remaining`=3, `score`=1, `display`=0x25.
- **Loss:** GUESSES=3, `board`=0x81, guesses 0x02, 0x04, 0x08 → `remaining` 2, 1, 0; then `lost`=1, `display`=0x81, `score` unchanged.
- **Repeat and zero guesses:** `board`=0x03.
  - Guess 0x01 twice → second guess leaves `remaining`=GUESSES and `found`=0x01.
  - Guess 0x00 → `remaining` decrements by 1.
  - Guess 0x03 → `found`=0x03, `won`=1.
- **Ignored inputs:**
  - `guess_valid` during SHOW, and on the SHOW→GUESS edge → no effect.
  - `start` during GUESS → `target`/`remaining` unchanged.
  - `start` in WIN with a new board → SHOW of the new board, `score` retained.
- **Reset mid-round and saturation:**
  - `reset` during GUESS → IDLE, `score`=0.
  - 256 consecutive won rounds (`board`=0) → `score` holds at 255.
